eth_unpacker: RTL and testbench

- RMII receive-side deframer; the receive counterpart of the team's RMII transmitter.
- Samples 2-bit RMII dibits at 50 MHz, locks onto preamble and delimiter, and strips destination, source and length fields.
- Streams payload dibits to downstream (bit-order reversal, then audio/pixel unpacking).
- Checks the 32-bit FCS and reports a per-frame good/bad status.

---
 rtl/eth_pkg.sv | 55 +++++
 rtl/eth_unpacker_if.sv | 24 ++
 rtl/eth_unpacker_crc32.sv | 49 ++++
 rtl/eth_unpacker.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_unpacker.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions for the RMII transmit and receive paths:
// field lengths, delimiter dibits, deframer states and dibit placement helpers.
package eth_pkg;

   localparam int unsigned ETH_PRE_MIN     = 12;
   localparam int unsigned ETH_ADDR_DIBITS = 24;
   localparam int unsigned ETH_LEN_DIBITS  = 8;
   localparam int unsigned ETH_DATA_DIBITS = 1280;
   localparam int unsigned ETH_FCS_DIBITS  = 16;
   localparam logic [47:0] ETH_MY_ADDR     = 48'h69695A065491;

   // wide enough for the longest field (payload)
   localparam int unsigned ETH_CNT_W       = 11;

   localparam int unsigned ETH_DELIM_LEN   = 5;
   localparam logic [1:0]  ETH_DELIM [ETH_DELIM_LEN] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b01};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELIM,
      ST_DEST,
      ST_SOURCE,
      ST_LENGTH,
      ST_DATA,
      ST_FCS,
      ST_DRAIN
   } eth_state_e;

   // FCS dibit n (byte j = n/4, dibit k = n%4) lands at bit 24-8j+2k of the
   // assembled FCS word, so the first wire byte ends up in [31:24]
   function automatic logic [4:0] fcs_dibit_lsb(input logic [3:0] n);
      int unsigned j;
      int unsigned k;
      j = 32'(n[3:2]);
      k = 32'(n[1:0]);
      return 5'(24 - 8 * j + 2 * k);
   endfunction

   // length dibit n: first byte is length[15:8], LSB-first within the byte
   function automatic logic [3:0] len_dibit_lsb(input logic [2:0] n);
      int unsigned j;
      int unsigned k;
      j = 32'(n[2]);
      k = 32'(n[1:0]);
      return 4'(8 * (1 - j) + 2 * k);
   endfunction

   // address dibit n as it appears on the wire: MSB byte first, LSB-first within the byte
   function automatic logic [1:0] addr_dibit(input logic [47:0] addr, input logic [4:0] n);
      int unsigned pos;
      pos = 8 * (5 - 32'(n[4:2])) + 2 * 32'(n[1:0]);
      return addr[pos +: 2];
   endfunction

endpackage

// File: rtl/eth_unpacker_if.sv
// RMII receive bus plus the deframed payload/status outputs of eth_unpacker.
interface eth_unpacker_if;

   logic        crsdv;
   logic [1:0]  rxd;
   logic        axiov;
   logic [1:0]  axiod;
   logic [15:0] length;
   logic        frame_done;
   logic        frame_ok;

   // master: PHY side driving dibits and observing the deframer
   modport master (
      output crsdv, rxd,
      input  axiov, axiod, length, frame_done, frame_ok
   );

   // slave: the deframer itself
   modport slave (
      input  crsdv, rxd,
      output axiov, axiod, length, frame_done, frame_ok
   );

endinterface

// File: rtl/eth_unpacker_crc32.sv
// Dibit-serial Ethernet CRC-32 (reflected 0xEDB88320, init all-ones).
// axiod presents the final (inverted) CRC with bytes swapped so the byte sent
// first on the wire sits in [31:24]; axiov is high once any dibit was absorbed.
module crc32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   output logic        axiov,
   output logic [31:0] axiod
);

   localparam logic [31:0] POLY = 32'hEDB88320;

   logic [31:0] lfsr_q, lfsr_d;
   logic        seen_q, seen_d;
   logic        fb;
   logic [31:0] crc;

   // absorb two bits per cycle, bit 0 first
   always_comb begin
      lfsr_d = lfsr_q;
      seen_d = seen_q;
      fb     = 1'b0;
      if (axiiv) begin
         for (int unsigned i = 0; i < 2; i++) begin
            fb     = lfsr_d[0] ^ axiid[i];
            lfsr_d = {1'b0, lfsr_d[31:1]} ^ (fb ? POLY : '0);
         end
         seen_d = 1'b1;
      end
   end

   // CRC state register
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= '1;
         seen_q <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         seen_q <= seen_d;
      end
   end

   assign crc   = ~lfsr_q;
   assign axiod = {crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
   assign axiov = seen_q;

endmodule

// File: rtl/eth_unpacker.sv
// RMII receive deframer: locks on preamble + delimiter, skips the address
// fields, captures length, streams payload dibits and checks the FCS.
// Optional destination filter: define ETH_UNPACKER_DEST_FILTER_EN.
module eth_unpacker
   import eth_pkg::*;
#(
   parameter int unsigned PRE_MIN     = ETH_PRE_MIN,
   parameter int unsigned ADDR_DIBITS = ETH_ADDR_DIBITS,
   parameter int unsigned LEN_DIBITS  = ETH_LEN_DIBITS,
   parameter int unsigned DATA_DIBITS = ETH_DATA_DIBITS,
   parameter int unsigned FCS_DIBITS  = ETH_FCS_DIBITS
`ifdef ETH_UNPACKER_DEST_FILTER_EN
   ,
   parameter logic [47:0] MY_ADDR     = ETH_MY_ADDR
`endif
) (
   input logic           clk,
   input logic           rst,
   eth_unpacker_if.slave bus
);

   localparam logic [ETH_CNT_W-1:0] PRE_LIM    = ETH_CNT_W'(PRE_MIN);
   localparam logic [ETH_CNT_W-1:0] DELIM_LAST = ETH_CNT_W'(ETH_DELIM_LEN - 1);
   localparam logic [ETH_CNT_W-1:0] ADDR_LAST  = ETH_CNT_W'(ADDR_DIBITS - 1);
   localparam logic [ETH_CNT_W-1:0] LEN_LAST   = ETH_CNT_W'(LEN_DIBITS - 1);
   localparam logic [ETH_CNT_W-1:0] DATA_LAST  = ETH_CNT_W'(DATA_DIBITS - 1);
   localparam logic [ETH_CNT_W-1:0] FCS_LAST   = ETH_CNT_W'(FCS_DIBITS - 1);

   eth_state_e           state_q, state_d;
   logic [ETH_CNT_W-1:0] cnt_q, cnt_d;
   logic                 armed_q, armed_d;
   logic [15:0]          length_q, length_d;
   logic [31:0]          fcs_rx_q, fcs_rx_d;
   logic                 axiov_q, axiov_d;
   logic [1:0]           axiod_q, axiod_d;
   logic                 done_q, done_d;
   logic                 ok_q, ok_d;

   logic                 in_frame;
   logic                 field_last;
   logic                 dest_ok;
   logic                 crc_rst;
   logic                 crc_feed;
   logic                 crc_valid;
   logic [31:0]          crc_out;

   assign in_frame = state_q inside {ST_DEST, ST_SOURCE, ST_LENGTH, ST_DATA, ST_FCS};
   assign crc_rst  = rst || (state_q inside {ST_IDLE, ST_DELIM, ST_DRAIN});
   assign crc_feed = bus.crsdv && (state_q inside {ST_DEST, ST_SOURCE, ST_LENGTH, ST_DATA});

   crc32 u_crc32 (
      .clk   (clk),
      .rst   (crc_rst),
      .axiiv (crc_feed),
      .axiid (bus.rxd),
      .axiov (crc_valid),
      .axiod (crc_out)
   );

`ifdef ETH_UNPACKER_DEST_FILTER_EN
   logic bcast_q, bcast_d;
   logic mine_q, mine_d;

   // running match of the destination against broadcast and this station,
   // including the dibit currently on rxd
   always_comb begin
      bcast_d = 1'b1;
      mine_d  = 1'b1;
      if (state_q == ST_DEST) begin
         bcast_d = bcast_q && (bus.rxd == 2'b11);
         mine_d  = mine_q && (bus.rxd == addr_dibit(MY_ADDR, cnt_q[4:0]));
      end
      dest_ok = bcast_d || mine_d;
   end

   // destination match flags
   always_ff @(posedge clk) begin
      if (rst) begin
         bcast_q <= 1'b1;
         mine_q  <= 1'b1;
      end else begin
         bcast_q <= bcast_d;
         mine_q  <= mine_d;
      end
   end
`else
   // every destination is accepted
   always_comb dest_ok = 1'b1;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next state and per-field dibit counter; in Idle the counter holds the
   // preamble run length, in Delim the delimiter index
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      field_last = 1'b0;
      case (state_q)
         ST_DEST, ST_SOURCE: field_last = (cnt_q == ADDR_LAST);
         ST_LENGTH:          field_last = (cnt_q == LEN_LAST);
         ST_DATA:            field_last = (cnt_q == DATA_LAST);
         ST_FCS:             field_last = (cnt_q == FCS_LAST);
         default:            field_last = 1'b0;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.crsdv || !armed_q) begin
               cnt_d = '0;
            end else if (bus.rxd == 2'b01) begin
               cnt_d = (cnt_q < PRE_LIM) ? cnt_q + 1'b1 : cnt_q;
            end else if (bus.rxd == 2'b11 && cnt_q >= PRE_LIM) begin
               state_d = ST_DELIM;
               cnt_d   = ETH_CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         ST_DELIM: begin
            if (!bus.crsdv) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (bus.rxd != ETH_DELIM[cnt_q[2:0]]) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == DELIM_LAST) begin
               state_d = ST_DEST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DEST, ST_SOURCE, ST_LENGTH, ST_DATA, ST_FCS: begin
            if (!bus.crsdv) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (field_last) begin
               cnt_d = '0;
               case (state_q)
                  ST_DEST:   state_d = dest_ok ? ST_SOURCE : ST_DRAIN;
                  ST_SOURCE: state_d = ST_LENGTH;
                  ST_LENGTH: state_d = ST_DATA;
                  ST_DATA:   state_d = ST_FCS;
                  default:   state_d = ST_DRAIN;
               endcase
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            cnt_d = '0;
            if (!bus.crsdv) state_d = ST_IDLE;
         end
      endcase
   end

   // preamble hunting is only armed once the carrier has been low in Idle
   assign armed_d = (state_d == ST_IDLE) && (!bus.crsdv || armed_q);

   // outputs, length capture and FCS assembly
   always_comb begin
      axiov_d  = 1'b0;
      axiod_d  = '0;
      done_d   = 1'b0;
      ok_d     = 1'b0;
      length_d = length_q;
      fcs_rx_d = fcs_rx_q;
      if (in_frame && !bus.crsdv) begin
         done_d = 1'b1;
      end else begin
         case (state_q)
            ST_LENGTH: length_d[len_dibit_lsb(cnt_q[2:0]) +: 2] = bus.rxd;
            ST_DATA: begin
               axiov_d = 1'b1;
               axiod_d = bus.rxd;
            end
            ST_FCS: begin
               fcs_rx_d[fcs_dibit_lsb(cnt_q[3:0]) +: 2] = bus.rxd;
               if (cnt_q == FCS_LAST) begin
                  done_d = 1'b1;
                  ok_d   = crc_valid && (fcs_rx_d == crc_out);
               end
            end
            default: ;
         endcase
      end
   end

   // datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         length_q <= '0;
         fcs_rx_q <= '0;
         axiov_q  <= 1'b0;
         axiod_q  <= '0;
         done_q   <= 1'b0;
         ok_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         length_q <= length_d;
         fcs_rx_q <= fcs_rx_d;
         axiov_q  <= axiov_d;
         axiod_q  <= axiod_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
      end
   end

   assign bus.axiov      = axiov_q;
   assign bus.axiod      = axiod_q;
   assign bus.length     = length_q;
   assign bus.frame_done = done_q;
   assign bus.frame_ok   = ok_q;

endmodule

// File: tb/tb_eth_unpacker.sv
// Directed bench for eth_unpacker: builds complete RMII frames (standard
// Ethernet CRC-32, FCS sent LSB byte first) and checks payload streaming,
// length capture, frame status, carrier loss, reset and preamble length.
module tb_eth_unpacker;

   logic clk;
   logic rst;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;

   logic [1:0]  tx_q [$];
   logic [1:0]  exp_pay [1280];
   int unsigned data0;
   int unsigned drv_cyc;

   // monitor state (written only by the monitor)
   int unsigned run_idx = 0;
   int unsigned beats_tot = 0;
   int unsigned dones_tot = 0;
   int unsigned first_beat_cyc = 0;
   int unsigned last_beat_cyc = 0;
   int unsigned done_cyc = 0;
   logic        last_ok = 1'b0;

   eth_unpacker_if bus ();

   eth_unpacker u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // payload and status monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (bus.axiov === 1'b1) begin
         if (run_idx == 0) first_beat_cyc = cyc;
         check_eq("axiod", 32'(bus.axiod), (run_idx < 1280) ? 32'(exp_pay[run_idx]) : 32'hDEAD);
         run_idx++;
         beats_tot++;
         last_beat_cyc = cyc;
      end else begin
         run_idx = 0;
      end
      if (bus.frame_done === 1'b1) begin
         dones_tot++;
         last_ok  = bus.frame_ok;
         done_cyc = cyc;
      end
   end

   task automatic build_frame(input int unsigned pre_len, input logic [47:0] dest,
                              input int corrupt_at, input int unsigned trail);
      logic [7:0]  fb [$];
      logic [31:0] c;
      logic [47:0] src;
      src = 48'h0A0B0C0D0E0F;
      fb  = {};
      for (int i = 5; i >= 0; i--) fb.push_back(dest[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fb.push_back(src[8*i +: 8]);
      fb.push_back(8'hAB);
      fb.push_back(8'hCD);
      // counting payload 0,1,2,3 LSB-first packs to 0xE4 per byte
      for (int i = 0; i < 320; i++) fb.push_back(8'hE4);
      c = '1;
      foreach (fb[i]) begin
         for (int b = 0; b < 8; b++) begin
            if (c[0] ^ fb[i][b]) c = (c >> 1) ^ 32'hEDB88320;
            else                 c = c >> 1;
         end
      end
      c = ~c;
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
      tx_q = {};
      repeat (pre_len) tx_q.push_back(2'b01);
      tx_q.push_back(2'b11);
      tx_q.push_back(2'b01);
      tx_q.push_back(2'b11);
      tx_q.push_back(2'b01);
      tx_q.push_back(2'b01);
      foreach (fb[i]) begin
         for (int k = 0; k < 4; k++) tx_q.push_back(fb[i][2*k +: 2]);
      end
      repeat (trail) tx_q.push_back(2'b01);
      data0 = pre_len + 61;
      for (int i = 0; i < 1280; i++) exp_pay[i] = 2'(i % 4);
      if (corrupt_at >= 0) begin
         exp_pay[corrupt_at]     = 2'b10;
         tx_q[data0 + corrupt_at] = 2'b10;
      end
   endtask

   // drive n_send dibits with carrier up, optional 1-cycle reset at index rst_at,
   // then drop carrier and idle a few cycles
   task automatic drive(input int unsigned n_send, input int rst_at);
      for (int unsigned i = 0; i < n_send; i++) begin
         @(posedge clk);
         #1;
         bus.crsdv = 1'b1;
         bus.rxd   = tx_q[i];
         rst       = (int'(i) == rst_at);
         if (i == data0) drv_cyc = cyc;
      end
      @(posedge clk);
      #1;
      bus.crsdv = 1'b0;
      bus.rxd   = 2'b00;
      rst       = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic expect_frame(input string tag, input int unsigned n_send, input int rst_at,
                               input int unsigned exp_beats, input int unsigned exp_dones,
                               input logic exp_ok);
      int unsigned b0;
      int unsigned d0;
      b0 = beats_tot;
      d0 = dones_tot;
      drive(n_send, rst_at);
      check_eq({tag, "_beats"}, beats_tot - b0, exp_beats);
      check_eq({tag, "_dones"}, dones_tot - d0, exp_dones);
      if (exp_dones != 0) check_eq({tag, "_ok"}, 32'(last_ok), 32'(exp_ok));
   endtask

   initial begin
      rst       = 1'b1;
      bus.crsdv = 1'b0;
      bus.rxd   = 2'b00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("rst_axiov", 32'(bus.axiov), 32'h0);
      check_eq("rst_axiod", 32'(bus.axiod), 32'h0);
      check_eq("rst_length", 32'(bus.length), 32'h0);
      check_eq("rst_done", 32'(bus.frame_done), 32'h0);
      check_eq("rst_ok", 32'(bus.frame_ok), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // good broadcast frame
      build_frame(28, 48'hFFFFFFFFFFFF, -1, 0);
      expect_frame("good", tx_q.size(), -1, 1280, 1, 1'b1);
      check_eq("good_length", 32'(bus.length), 32'h0000ABCD);
      check_eq("good_lag", first_beat_cyc, drv_cyc + 1);
      check_eq("good_done_time", done_cyc, drv_cyc + 1296);

      // payload dibit 500 corrupted after the FCS was computed
      build_frame(28, 48'hFFFFFFFFFFFF, 500, 0);
      expect_frame("crc_bad", tx_q.size(), -1, 1280, 1, 1'b0);

      // preamble too short: 8 and PRE_MIN-1, then exactly PRE_MIN
      build_frame(8, 48'hFFFFFFFFFFFF, -1, 0);
      expect_frame("pre8", tx_q.size(), -1, 0, 0, 1'b0);
      build_frame(11, 48'hFFFFFFFFFFFF, -1, 0);
      expect_frame("pre11", tx_q.size(), -1, 0, 0, 1'b0);
      build_frame(12, 48'hFFFFFFFFFFFF, -1, 0);
      expect_frame("pre12", tx_q.size(), -1, 1280, 1, 1'b1);

      // carrier lost after 300 payload dibits
      build_frame(28, 48'hFFFFFFFFFFFF, -1, 0);
      expect_frame("drop", data0 + 300, -1, 300, 1, 1'b0);
      check_eq("drop_done_time", done_cyc, last_beat_cyc + 1);
      check_eq("drop_axiov_low", 32'(bus.axiov), 32'h0);
      expect_frame("after_drop", tx_q.size(), -1, 1280, 1, 1'b1);

      // reset pulse in the middle of the source address
      build_frame(28, 48'hFFFFFFFFFFFF, -1, 0);
      expect_frame("rst_src", tx_q.size(), 28 + 5 + 24 + 10, 0, 0, 1'b0);
      check_eq("rst_src_length", 32'(bus.length), 32'h0);
      check_eq("rst_src_axiov", 32'(bus.axiov), 32'h0);
      check_eq("rst_src_ok", 32'(bus.frame_ok), 32'h0);
      expect_frame("after_rst", tx_q.size(), -1, 1280, 1, 1'b1);

      // unicast destination, with trailing dibits after the FCS
      build_frame(28, 48'h001122334455, -1, 20);
`ifdef ETH_UNPACKER_DEST_FILTER_EN
      expect_frame("other_dest", tx_q.size(), -1, 0, 0, 1'b0);
      build_frame(28, 48'h69695A065491, -1, 0);
      expect_frame("my_dest", tx_q.size(), -1, 1280, 1, 1'b1);
`else
      expect_frame("trail", tx_q.size(), -1, 1280, 1, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
